// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, slave FSM states and the byte-lane strobe helper
// used by the SRAM-backed AHB-lite slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Little-endian lane mask for up to 8 lanes; callers keep the low DATA_WIDTH/8 bits.
  function automatic logic [7:0] byte_strobe(input logic [2:0] addr_lsb,
                                             input logic [2:0] hsize);
    logic [15:0] m;
    case (hsize)
      3'd0:    m = 16'h0001;
      3'd1:    m = 16'h0003;
      3'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << addr_lsb;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enable SRAM with a registered, enable-gated read port; a same-edge write
// to the read word is merged lane by lane into the read data.
module ahb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
      if (we && (waddr == raddr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[b]) rdata_d[b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data holds between reads so hrdata stays stable on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave: address/control pipeline, wait-state and two-cycle ERROR FSM
// in front of a byte-addressable SRAM.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NB);

  slave_state_e   state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           write_q, write_d;
  logic [MAW-1:0] idx_q, idx_d;
  logic [LSB-1:0] lsb_q, lsb_d;
  logic [2:0]     size_q, size_d;

  htrans_e        trans;
  logic           ready, take, err, misalign, mem_we, mem_re;
  logic [LSB-1:0] amask;
  logic [NB-1:0]  mem_strb;
  logic           unused_inputs;

  assign trans     = htrans_e'(htrans);
  assign ready     = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign take      = hsel && hready && ready &&
                     ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
  assign amask     = LSB'((32'd1 << hsize) - 32'd1);
  assign misalign  = |(haddr[LSB-1:0] & amask);
  assign err       = ({1'b0, haddr} >= MEM_BYTES) || (hsize > 3'(LSB)) || misalign;
  assign unused_inputs = ^{hburst, hprot};

  // IDLE, DATA and ERR2 are the ready states; each applies the same acceptance rules.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    lsb_d   = lsb_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'(WAIT_STATES - 1)) state_d = ST_DATA;
        else                              cnt_d   = cnt_q + 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        if (take) begin
          idx_d   = haddr[MAW+LSB-1:LSB];
          lsb_d   = haddr[LSB-1:0];
          size_d  = hsize;
          cnt_d   = '0;
          if (err) begin
            state_d = ST_ERR1;
          end else begin
            write_d = hwrite;
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
    end
  end

  always_ff @(posedge hclk) begin
    idx_q  <= idx_d;
    lsb_q  <= lsb_d;
    size_q <= size_d;
  end

  // Writes land on the completion edge; reads are launched at acceptance.
  assign mem_we   = (state_q == ST_DATA) && write_q;
  assign mem_re   = take && !err && !hwrite;
  assign mem_strb = NB'(byte_strobe(3'(lsb_q), size_q));

  ahb_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (hclk),
    .rst_n (hresetn),
    .we    (mem_we),
    .waddr (idx_q),
    .wstrb (mem_strb),
    .wdata (hwdata),
    .re    (mem_re),
    .raddr (haddr[MAW+LSB-1:LSB]),
    .rdata (hrdata)
  );

  assign hreadyout = ready;
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave: one zero-wait and one three-wait instance
// share the bus; per-instance queues hold hand-computed data-phase expectations.
module tb_ahb_lite_sram_slave;

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [1:0]  hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata0, hrdata1;

  exp_t        sbq0[$];
  exp_t        sbq1[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] wd_pend;
  logic [1:0]  acc;
  logic [1:0]  active;
  int          waits [2];
  logic [1:0]  wresp;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready[0]),
    .hwdata(hwdata), .hreadyout(hready[0]), .hresp(hresp[0]), .hrdata(hrdata0));

  ahb_lite_sram_slave #(.WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready[1]),
    .hwdata(hwdata), .hreadyout(hready[1]), .hresp(hresp[1]), .hrdata(hrdata1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input int i);
    return (i == 0) ? hrdata0 : hrdata1;
  endfunction

  // Acceptance is sampled just before each rising edge, after inputs have settled.
  initial begin
    acc = '0;
    forever begin
      @(negedge hclk);
      #3;
      for (int i = 0; i < 2; i++)
        acc[i] = hresetn && hsel[i] && hready[i] && htrans[1];
    end
  end

  initial begin
    exp_t e;
    active = '0;
    wresp  = '0;
    waits[0] = 0;
    waits[1] = 0;
    forever begin
      @(negedge hclk);
      for (int i = 0; i < 2; i++) begin
        if (!hresetn) begin
          active[i] = 1'b0;
        end else begin
          if (acc[i]) begin
            active[i] = 1'b1;
            waits[i]  = 0;
            wresp[i]  = 1'b0;
          end
          if (active[i]) begin
            if (!hready[i]) begin
              waits[i]++;
              wresp[i] = hresp[i];
            end else begin
              active[i] = 1'b0;
              if (((i == 0) ? sbq0.size() : sbq1.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: inst %0d completed a transfer, none queued", i);
              end else begin
                if (i == 0) e = sbq0.pop_front();
                else        e = sbq1.pop_front();
                chk({e.name, "_resp"}, 32'(hresp[i]), 32'(e.resp));
                chk({e.name, "_waits"}, 32'(waits[i]), 32'(e.waits));
                if (e.waits > 0) chk({e.name, "_wait_resp"}, 32'(wresp[i]), 32'(e.resp));
                if (e.rd && !e.resp) chk({e.name, "_data"}, rdat(i), e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_rdy(input int inst);
    int n = 0;
    while (!hready[inst] && n < 20) begin
      @(posedge hclk);
      @(negedge hclk);
      n++;
    end
    if (!hready[inst]) begin
      checks++;
      failures++;
      $display("FAIL timeout: inst %0d hreadyout stuck low, got 0 required 1", inst);
    end
  endtask

  task automatic xfer(input int inst, input logic [31:0] addr, input logic wr,
                      input logic [2:0] sz, input logic [1:0] tr, input logic [31:0] wd,
                      input logic [31:0] rexp, input logic eresp, input string name);
    exp_t e;
    e.name  = name;
    e.rd    = !wr;
    e.data  = rexp;
    e.resp  = eresp;
    e.waits = eresp ? 1 : ((inst == 0) ? 0 : 3);
    if (inst == 0) sbq0.push_back(e);
    else           sbq1.push_back(e);
    hsel   = (inst == 0) ? 2'b01 : 2'b10;
    haddr  = addr;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    hwdata = wd_pend;
    wait_rdy(inst);
    @(posedge hclk);
    @(negedge hclk);
    wd_pend = wd;
  endtask

  task automatic idle(input int inst);
    htrans = 2'd0;
    hwdata = wd_pend;
    wait_rdy(inst);
    @(posedge hclk);
    @(negedge hclk);
  endtask

  initial begin
    int c0;
    hresetn = 1'b0;
    hsel = 2'b00; haddr = '0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'd0; hwdata = '0; wd_pend = '0;
    repeat (2) @(negedge hclk);
    #1;
    chk("rst_ready0", 32'(hready[0]), 32'd1);
    chk("rst_resp0",  32'(hresp[0]),  32'd0);
    chk("rst_rdata0", hrdata0,        32'd0);
    chk("rst_ready1", 32'(hready[1]), 32'd1);
    chk("rst_resp1",  32'(hresp[1]),  32'd0);
    chk("rst_rdata1", hrdata1,        32'd0);
    @(negedge hclk);
    #2 hresetn = 1'b1;
    @(negedge hclk);

    // Zero-wait word write then pipelined read.
    xfer(0, 32'h10, 1'b1, 3'd2, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0, "w10");
    xfer(0, 32'h10, 1'b0, 3'd2, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0, "r10");
    idle(0);

    // Narrow lanes: byte @0x21 then halfword @0x22 over a full word.
    xfer(0, 32'h20, 1'b1, 3'd2, 2'd2, 32'h11223344, 32'h0, 1'b0, "w20");
    xfer(0, 32'h21, 1'b1, 3'd0, 2'd2, 32'h5566AA77, 32'h0, 1'b0, "wb21");
    xfer(0, 32'h20, 1'b0, 3'd2, 2'd2, 32'h0, 32'h1122AA44, 1'b0, "r20_byte");
    xfer(0, 32'h22, 1'b1, 3'd1, 2'd2, 32'hBEEF1234, 32'h0, 1'b0, "wh22");
    xfer(0, 32'h20, 1'b0, 3'd2, 2'd2, 32'h0, 32'hBEEFAA44, 1'b0, "r20_half");
    idle(0);

    // Write immediately followed by read of the same word.
    xfer(0, 32'h40, 1'b1, 3'd2, 2'd2, 32'h0BADC0DE, 32'h0, 1'b0, "w40");
    xfer(0, 32'h40, 1'b0, 3'd2, 2'd2, 32'h0, 32'h0BADC0DE, 1'b0, "r40_bypass");
    idle(0);

    // Error responses: out of range, misaligned, oversize; memory must stay intact.
    xfer(0, 32'h0, 1'b1, 3'd2, 2'd2, 32'hCAFEF00D, 32'h0, 1'b0, "w00");
    idle(0);
    xfer(0, 32'h1000, 1'b1, 3'd2, 2'd2, 32'h12345678, 32'h0, 1'b1, "err_range_w");
    idle(0);
    xfer(0, 32'h3, 1'b1, 3'd1, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1, "err_misalign");
    idle(0);
    xfer(0, 32'h10, 1'b1, 3'd3, 2'd2, 32'h0, 32'h0, 1'b1, "err_size");
    idle(0);
    xfer(0, 32'h1000, 1'b0, 3'd2, 2'd2, 32'h0, 32'h0, 1'b1, "err_range_r");
    idle(0);
    xfer(0, 32'h0, 1'b0, 3'd2, 2'd2, 32'h0, 32'hCAFEF00D, 1'b0, "r00_after_err");
    xfer(0, 32'h10, 1'b0, 3'd2, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0, "r10_after_err");
    idle(0);

    // Three wait states: single write/read, then an INCR4 write burst.
    xfer(1, 32'h50, 1'b1, 3'd2, 2'd2, 32'h55667788, 32'h0, 1'b0, "ws_w50");
    idle(1);
    xfer(1, 32'h50, 1'b0, 3'd2, 2'd2, 32'h0, 32'h55667788, 1'b0, "ws_r50");
    idle(1);
    hburst = 3'd3;
    xfer(1, 32'h60, 1'b1, 3'd2, 2'd2, 32'hA0A0A0A0, 32'h0, 1'b0, "burst_b0");
    c0 = cyc;
    xfer(1, 32'h64, 1'b1, 3'd2, 2'd3, 32'hA1A1A1A1, 32'h0, 1'b0, "burst_b1");
    xfer(1, 32'h68, 1'b1, 3'd2, 2'd3, 32'hA2A2A2A2, 32'h0, 1'b0, "burst_b2");
    xfer(1, 32'h6C, 1'b1, 3'd2, 2'd3, 32'hA3A3A3A3, 32'h0, 1'b0, "burst_b3");
    idle(1);
    chk("burst_cycles", 32'(cyc - c0), 32'd16);
    hburst = 3'd0;
    xfer(1, 32'h64, 1'b0, 3'd2, 2'd2, 32'h0, 32'hA1A1A1A1, 1'b0, "burst_r64");
    xfer(1, 32'h6C, 1'b0, 3'd2, 2'd2, 32'h0, 32'hA3A3A3A3, 1'b0, "burst_r6c");
    idle(1);

    // Reset during the wait states of a write abandons it.
    hsel = 2'b10; haddr = 32'h50; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
    hwdata = wd_pend;
    wait_rdy(1);
    @(posedge hclk);
    @(negedge hclk);
    htrans = 2'd0;
    hwdata = 32'h99999999;
    @(posedge hclk);
    #2 hresetn = 1'b0;
    #1;
    chk("midrst_ready", 32'(hready[1]), 32'd1);
    chk("midrst_resp",  32'(hresp[1]),  32'd0);
    chk("midrst_rdata", hrdata1,        32'd0);
    @(negedge hclk);
    #2 hresetn = 1'b1;
    @(negedge hclk);
    xfer(1, 32'h50, 1'b0, 3'd2, 2'd2, 32'h0, 32'h55667788, 1'b0, "midrst_r50");
    idle(1);

    repeat (3) @(negedge hclk);
    chk("sb_drain", 32'(sbq0.size() + sbq1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

endmodule
